mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder that terminates the cache's backing-store interface. It services one word read or write at a time out of a word-addressed storage array, with a configurable fixed latency and a ready/valid handshake. The cache controller (or a bench) uses it in place of a zero-latency memory so that line fills and write-backs see realistic wait states.

Parameters:
ADDR_WIDTH, 10, word-index bits; storage holds 2**ADDR_WIDTH 32-bit words (4 KiB by default).
LATENCY, 4, cycles from request to response. Must be >= 1; elaboration fails if it is 0.

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  synchronous active-high reset
req_i  input  1  request valid from the cache side
wen_i  input  1  1 = write, 0 = read; sampled with req_i
addr_i  input  32  byte address; word index is addr_i[ADDR_WIDTH+1:2]
wdata_i  input  32  write data; sampled with req_i
ready_o  output  1  high when a request can be accepted
resp_valid_o  output  1  one-cycle pulse marking completion
rdata_o  output  32  read data (write data echoed for writes), valid with resp_valid_o
err_o  output  1  request was misaligned or out of range; valid with resp_valid_o

Behaviour:
- FSM states: IDLE, WAIT, RESP. ready_o = (state == IDLE), driven combinationally from the state register.
- Accept: in IDLE, a rising edge with req_i = 1 latches addr_i, wen_i and wdata_i.
  - LATENCY = 1: next state RESP.
  - Otherwise: next state WAIT, with cnt = LATENCY-2.
- WAIT: cnt decrements each edge. At the edge where cnt == 0, the FSM goes to RESP.
- Timing: if the request is sampled at the end of cycle 0, resp_valid_o is high in cycle LATENCY for exactly one cycle. RESP always returns to IDLE. The next request can be accepted at the end of cycle LATENCY+1 at the earliest.
- Commit happens at the edge entering RESP:
  - Legal write: mem[idx] <= wdata; rdata_o <= wdata.
  - Legal read: rdata_o <= mem[idx].
  - err_o <= 0 for a legal request.
- Error: addr[1:0] != 0 or addr[31:ADDR_WIDTH+2] != 0.
  - No storage write; rdata_o <= 0; err_o <= 1.
  - Latency is unchanged.
- rdata_o and err_o hold their values until the next commit. resp_valid_o is 0 in all states except RESP.
- req_i while not ready_o is ignored: no queueing, no latching. Inputs may change freely after acceptance.
- Read-after-write to the same address returns the new data, because the write commits before a later request can be accepted.
- Reset values: state IDLE, so ready_o = 1 and resp_valid_o = 0. rdata_o = 0, err_o = 0, cnt = 0.
- Storage contents are not cleared by reset. They are undefined at power-up.
- Reset mid-operation: reset has priority at every edge. An in-flight request is discarded.
  - If reset is high at the edge that would enter RESP, the write is not committed.
  - No response pulse is produced.
- Reset high with req_i high: the request is not accepted.

Test Plan:
- LATENCY=4: write 0xDEADBEEF to 0x0000_0010 (req in cycle 0) -> ready_o low in cycles 1-4; resp_valid_o high only in cycle 4 with rdata_o=0xDEADBEEF, err_o=0. Then read 0x10 -> rdata_o=0xDEADBEEF 4 cycles after acceptance.
- LATENCY=1: back-to-back reads of 0x0, 0x4 with req_i held high -> accepted in cycles 0 and 2; pulses in cycles 1 and 3; correct data each time.
- Misaligned 0x0000_0012 and out-of-range 0x0000_1000 (ADDR_WIDTH=10) writes -> err_o=1, rdata_o=0; a subsequent read of word 4 still returns the prior contents.
- req_i pulsed high with a different address in cycles 1-3 while busy -> ignored. Only the original request responds, and no extra pulse appears.
- Write 0x1234_5678 to 0x20, assert reset for one cycle at the edge that would enter RESP -> no resp_valid_o, ready_o=1 next cycle. A read of 0x20 returns the old value (preloaded 0xAAAA_AAAA).
- Reset after a successful write of 0x55 to 0x8 -> rdata_o=0, err_o=0, ready_o=1. A read of 0x8 returns 0x55, showing storage survives reset.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed backing store that answers one read or write at a time after a fixed latency.
// It stands in for main memory behind the cache, so line fills and write-backs see wait states.
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 2) ? LATENCY - 2 : 0);

    generate
        if (LATENCY < 1) begin : g_latency_check
            $error("mem_responder: LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wen_q, wen_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic                  cur_wen;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_err;
    logic                  commit;

    // With LATENCY == 1 the accepting edge is also the commit edge, so the live inputs feed the commit.
    always_comb begin
        if (state_q == IDLE) begin
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
            cur_wen   = wen_i;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_wen   = wen_q;
        end
        cur_idx = cur_addr[ADDR_WIDTH+1:2];
        cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wen_d   = wen_i;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d = cur_err;
            if (cur_err) begin
                rdata_d = '0;
            end else if (cur_wen) begin
                rdata_d = cur_wdata;
            end else begin
                rdata_d = mem[cur_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wen_q   <= wen_d;
    end

    // Storage is never cleared; reset only suppresses a commit that lands on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_wen && !cur_err) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder, run on a LATENCY=4 and a LATENCY=1 instance side by side.
module tb_mem_responder;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int NCYC  = 3000;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          err;
        bit          wen;
        bit          dknown;
        int unsigned idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [2];
    logic        req   [2];
    logic        wen   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        rdy   [2];
    logic        rv    [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(rst[0]), .req_i(req[0]), .wen_i(wen[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .ready_o(rdy[0]), .resp_valid_o(rv[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(rst[1]), .req_i(req[1]), .wen_i(wen[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .ready_o(rdy[1]), .resp_valid_o(rv[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    // Reference state: expected responses, memory image, and the last cycle each instance is busy.
    exp_t        sb [2][$];
    logic [31:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];
    int          busy_until [2];
    int          last_rst   [2];
    bit          drv_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        int          s = int'($urandom_range(0, 19));
        int unsigned w = $urandom_range(0, 7);
        if (s < 13) return 32'(w * 4);
        if (s < 15) return 32'((DEPTH - 1 - w) * 4);
        if (s < 17) return 32'(w * 4 + $urandom_range(1, 3));
        if (s < 18) return 32'(DEPTH * 4 + w * 4);
        return $urandom() | 32'h8000_0000;
    endfunction

    task automatic drive_one(input int i, input bit r, input bit allow_req);
        exp_t e;
        int   c = cyc;
        rst[i]   = r;
        req[i]   = allow_req && ($urandom_range(0, 9) < 6);
        wen[i]   = 1'($urandom_range(0, 1));
        addr[i]  = pick_addr();
        wdata[i] = $urandom();
        if (r) begin
            sb[i].delete();
            busy_until[i] = c;
            last_rst[i]   = c;
        end else if (req[i] && c > busy_until[i]) begin
            e.cyc    = c + lat(i);
            e.err    = (addr[i] % 4 != 0) || (longint'(addr[i]) >= longint'(DEPTH) * 4);
            e.idx    = (addr[i] / 4) % DEPTH;
            e.wen    = wen[i];
            e.dknown = 1'b1;
            if (e.err) begin
                e.data = 32'd0;
            end else if (wen[i]) begin
                e.data = wdata[i];
            end else begin
                e.data   = mdl[i][e.idx];
                e.dknown = known[i][e.idx];
            end
            sb[i].push_back(e);
            busy_until[i] = e.cyc;
        end
    endtask

    // Stimulus: drive just after the falling edge; expectations are pushed as each request is issued.
    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            busy_until[i] = 0;
            last_rst[i]   = -10;
            for (int j = 0; j < DEPTH; j++) begin
                mdl[i][j]   = '0;
                known[i][j] = 1'b0;
            end
        end
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                drive_one(i, (n < 2) || ($urandom_range(0, 39) == 0), (n < NCYC - 12));
            end
        end
        drv_done = 1'b1;
    end

    // Monitor: compares the DUT outputs of each cycle against the scoreboard at the falling edge.
    initial begin
        logic [31:0] hold_d  [2];
        bit          hold_e  [2];
        bit          hold_ok [2];
        exp_t        e;
        string       tag;
        for (int i = 0; i < 2; i++) begin
            hold_d[i] = '0; hold_e[i] = 1'b0; hold_ok[i] = 1'b0;
        end
        while (!drv_done) begin
            @(negedge clk);
            if (cyc >= 2) begin
                for (int i = 0; i < 2; i++) begin
                    tag = $sformatf("L%0d", lat(i));
                    if (last_rst[i] == cyc - 1) begin
                        hold_d[i] = '0; hold_e[i] = 1'b0; hold_ok[i] = 1'b1;
                    end
                    chk({tag, "_ready"}, 32'(rdy[i]), 32'(cyc > busy_until[i]));
                    if (sb[i].size() > 0 && sb[i][0].cyc == cyc) begin
                        e = sb[i].pop_front();
                        chk({tag, "_resp_valid"}, 32'(rv[i]), 32'd1);
                        chk({tag, "_err"}, 32'(err[i]), 32'(e.err));
                        if (e.dknown) chk({tag, "_rdata"}, rdata[i], e.data);
                        if (!e.err && e.wen) begin
                            mdl[i][e.idx]   = e.data;
                            known[i][e.idx] = 1'b1;
                        end
                        hold_d[i]  = e.data;
                        hold_e[i]  = e.err;
                        hold_ok[i] = e.dknown;
                    end else begin
                        chk({tag, "_no_resp"}, 32'(rv[i]), 32'd0);
                        if (hold_ok[i]) chk({tag, "_rdata_hold"}, rdata[i], hold_d[i]);
                        chk({tag, "_err_hold"}, 32'(err[i]), 32'(hold_e[i]));
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("L%0d_drained", lat(i)), 32'(sb[i].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
